// File: rtl/dp_seq_ctrl.sv
// Layer sequencer for the convolution/dot-product datapath: walks every tile of a layer
// and emits the per-cycle npu, kernel-step and result-pipe strobes from terminal-count flags.
module dp_seq_ctrl #(
    parameter int PIPE_LAT = 3,
    parameter int TCNT_W   = 16
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              stall,
    input  logic              s_tc_npu_ptr,
    input  logic              s_tc_hmode,
    input  logic              s_tc_vmode,
    input  logic              s_tc_res,
    input  logic              s_tc_tilev,
    input  logic              s_tc_tileh,
    input  logic              s_tc_tileb,
    input  logic              s_tc_tilec,
    output logic              ctrl_en_npu,
    output logic              ctrl_ldh_v_n,
    output logic              ctrl_en_hmode,
    output logic              ctrl_en_vmode,
    output logic              ctrl_wr_pipe,
    output logic              busy,
    output logic              done,
    output logic [TCNT_W-1:0] tile_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOADV = 3'd1,
        S_HMODE = 3'd2,
        S_VSTEP = 3'd3,
        S_FLUSH = 3'd4,
        S_WRITE = 3'd5,
        S_NEXT  = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    localparam logic [3:0] FLUSH_INIT = 4'(PIPE_LAT - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_flush_cnt;
    logic [3:0]        w_flush_cnt_nxt;
    logic              r_last_tile;
    logic              w_last_tile_nxt;
    logic [TCNT_W-1:0] r_tile_cnt;
    logic [TCNT_W-1:0] w_tile_cnt_nxt;
    logic              w_hold;
    logic              w_last_flags;

    // stall only freezes the active walk; IDLE and DONE always advance
    assign w_hold       = stall && (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_last_flags = s_tc_tilev & s_tc_tileh & s_tc_tileb & s_tc_tilec;

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_flush_cnt <= 4'd0;
            r_last_tile <= 1'b0;
            r_tile_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            r_last_tile <= w_last_tile_nxt;
            r_tile_cnt  <= w_tile_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        w_last_tile_nxt = r_last_tile;
        w_tile_cnt_nxt  = r_tile_cnt;
        if (abort) begin
            w_state_nxt = S_IDLE;
        end else if (!w_hold) begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_state_nxt    = S_LOADV;
                        w_tile_cnt_nxt = '0;
                    end
                end
                S_LOADV: begin
                    if (s_tc_npu_ptr) begin
                        w_state_nxt = S_HMODE;
                    end
                end
                S_HMODE: begin
                    if (s_tc_hmode) begin
                        if (s_tc_vmode) begin
                            w_state_nxt     = S_FLUSH;
                            w_flush_cnt_nxt = FLUSH_INIT;
                        end else begin
                            w_state_nxt = S_VSTEP;
                        end
                    end
                end
                S_VSTEP: begin
                    w_state_nxt = S_HMODE;
                end
                S_FLUSH: begin
                    if (r_flush_cnt == 4'd0) begin
                        w_state_nxt = S_WRITE;
                    end else begin
                        w_flush_cnt_nxt = r_flush_cnt - 4'd1;
                    end
                end
                S_WRITE: begin
                    if (s_tc_res) begin
                        w_last_tile_nxt = w_last_flags;
                        w_tile_cnt_nxt  = r_tile_cnt + TCNT_W'(1);
                        w_state_nxt     = S_NEXT;
                    end
                end
                S_NEXT: begin
                    w_state_nxt = r_last_tile ? S_DONE : S_LOADV;
                end
                S_DONE: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Moore strobe decode; a stall blanks every strobe in the same cycle
    always_comb begin
        ctrl_en_npu   = 1'b0;
        ctrl_ldh_v_n  = 1'b0;
        ctrl_en_hmode = 1'b0;
        ctrl_en_vmode = 1'b0;
        ctrl_wr_pipe  = 1'b0;
        case (r_state)
            S_LOADV: begin
                ctrl_en_npu  = !stall;
                ctrl_ldh_v_n = !stall;
            end
            S_HMODE: begin
                ctrl_en_npu   = !stall;
                ctrl_en_hmode = !stall;
            end
            S_VSTEP: begin
                ctrl_en_npu   = !stall;
                ctrl_en_vmode = !stall;
            end
            S_FLUSH: begin
                ctrl_en_npu = !stall;
            end
            S_WRITE: begin
                ctrl_en_npu  = !stall;
                ctrl_wr_pipe = !stall;
            end
            default: begin
                ctrl_en_npu = 1'b0;
            end
        endcase
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign tile_cnt = r_tile_cnt;

endmodule
